desired_drive_seq: RTL

Multi-cycle sequencer that computes the motor assist target current (target_curr) from conditioned sensor values.
- One 15x15 unsigned multiplier is time-shared across the three products of the assist equation, replacing three parallel multipliers to save area.
- Sits between the sensor-conditioning block, which issues start when it has fresh samples, and the PID/brushless drive path, which consumes target_curr.
- Start/done handshake; the result is held between computations.

---
 rtl/drive_pkg.sv | 49 ++++
 rtl/desired_drive_seq_if.sv | 23 ++
 rtl/shared_mult_15x15.sv | 11 +
 rtl/desired_drive_seq.sv | 117 +++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types, default tuning constants and operand preconditioning helpers
// for the assist-current sequencer.
package drive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_TS  = 2'd1,
    MUL_IC  = 2'd2,
    MUL_FIN = 2'd3
  } state_t;

  localparam logic [11:0] DEF_TORQUE_MIN = 12'h380;
  localparam int          DEF_INC_OFFSET = 256;
  localparam int          DEF_CAD_MIN    = 1;
  localparam int          DEF_CAD_OFFSET = 32;

  // Torque above the assist threshold; anything below the threshold gives no assist.
  function automatic logic [11:0] torque_offset(input logic [11:0] torque,
                                                input logic [11:0] tmin);
    if (torque < tmin) return 12'd0;
    return torque - tmin;
  endfunction

  // Narrow the 13-bit signed incline to 10-bit signed, clamping at the rails.
  function automatic logic signed [9:0] sat_incline(input logic signed [12:0] inc);
    if (inc > 13'sd511)       return 10'sd511;
    else if (inc < -13'sd512) return -10'sd512;
    else                      return $signed(inc[9:0]);
  endfunction

  // Bias the saturated incline and clip the sum into the unsigned 0..511 range.
  function automatic logic [8:0] clip_inc_lim(input logic signed [9:0] inc_sat,
                                              input int offset);
    int sum;
    sum = int'(inc_sat) + offset;
    if (sum < 0)   return 9'd0;
    if (sum > 511) return 9'd511;
    return sum[8:0];
  endfunction

  // Cadence contributes only once the rider is turning faster than the minimum.
  function automatic logic [5:0] cad_factor(input logic [4:0] cad,
                                            input int cmin,
                                            input int coff);
    if (int'(cad) > cmin) return 6'(int'(cad) + coff);
    return 6'd0;
  endfunction

endpackage

// File: rtl/desired_drive_seq_if.sv
// Handshake and operand bundle between sensor conditioning (master) and
// the assist-current sequencer (slave).
interface desired_drive_seq_if;
  logic               start;
  logic        [11:0] avg_torque;
  logic        [4:0]  cadence;
  logic               not_pedaling;
  logic signed [12:0] incline;
  logic        [2:0]  scale;
  logic        [11:0] target_curr;
  logic               done;
  logic               busy;

  modport master (
    output start, avg_torque, cadence, not_pedaling, incline, scale,
    input  target_curr, done, busy
  );

  modport slave (
    input  start, avg_torque, cadence, not_pedaling, incline, scale,
    output target_curr, done, busy
  );
endinterface

// File: rtl/shared_mult_15x15.sv
// Combinational unsigned 15x15 -> 30 multiplier, kept in its own module so
// synthesis can map it onto a hard multiplier or retime around it.
module shared_mult_15x15 (
  input  logic [14:0] a,
  input  logic [14:0] b,
  output logic [29:0] p
);

  assign p = a * b;

endmodule

// File: rtl/desired_drive_seq.sv
// Assist target-current sequencer: evaluates
//   target = sat12(((torque_pos*scale) * (inc_lim*cad_fac)) >> 15)
// over three clocks using one time-shared multiplier.
module desired_drive_seq
  import drive_pkg::*;
#(
  parameter logic [11:0] TORQUE_MIN = DEF_TORQUE_MIN,
  parameter int          INC_OFFSET = DEF_INC_OFFSET,
  parameter int          CAD_MIN    = DEF_CAD_MIN,
  parameter int          CAD_OFFSET = DEF_CAD_OFFSET
) (
  input  logic clk,
  input  logic rst_n,
  desired_drive_seq_if.slave bus
);

  state_t      state;

  logic [11:0] torque_pos_r;
  logic [2:0]  scale_r;
  logic [8:0]  inc_lim_r;
  logic [5:0]  cad_fac_r;
  logic        np_r;

  logic [14:0] ts_reg;
  logic [14:0] ic_reg;

  logic [14:0] mult_a;
  logic [14:0] mult_b;
  logic [29:0] mult_p;

  logic [11:0] target_curr_r;
  logic        done_r;

  assign bus.target_curr = target_curr_r;
  assign bus.done        = done_r;
  assign bus.busy        = (state != IDLE);

  // Steer the shared multiplier by state; idle inputs are parked at zero.
  always_comb begin
    mult_a = 15'd0;
    mult_b = 15'd0;
    case (state)
      MUL_TS: begin
        mult_a = {3'd0, torque_pos_r};
        mult_b = {12'd0, scale_r};
      end
      MUL_IC: begin
        mult_a = {6'd0, inc_lim_r};
        mult_b = {9'd0, cad_fac_r};
      end
      MUL_FIN: begin
        mult_a = ts_reg;
        mult_b = ic_reg;
      end
      default: begin
        mult_a = 15'd0;
        mult_b = 15'd0;
      end
    endcase
  end

  shared_mult_15x15 u_mult (
    .a (mult_a),
    .b (mult_b),
    .p (mult_p)
  );

  // Sequencer FSM: latch preconditioned operands, run the three products,
  // then publish the saturated result with a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      torque_pos_r  <= 12'd0;
      scale_r       <= 3'd0;
      inc_lim_r     <= 9'd0;
      cad_fac_r     <= 6'd0;
      np_r          <= 1'b0;
      ts_reg        <= 15'd0;
      ic_reg        <= 15'd0;
      target_curr_r <= 12'd0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            torque_pos_r <= torque_offset(bus.avg_torque, TORQUE_MIN);
            scale_r      <= bus.scale;
            inc_lim_r    <= clip_inc_lim(sat_incline(bus.incline), INC_OFFSET);
            cad_fac_r    <= cad_factor(bus.cadence, CAD_MIN, CAD_OFFSET);
            np_r         <= bus.not_pedaling;
            state        <= MUL_TS;
          end
        end
        MUL_TS: begin
          ts_reg <= mult_p[14:0];
          state  <= MUL_IC;
        end
        MUL_IC: begin
          ic_reg <= mult_p[14:0];
          state  <= MUL_FIN;
        end
        MUL_FIN: begin
          // Anything at or above 2^27 would overflow 12 bits after the >>15.
          if (np_r)               target_curr_r <= 12'd0;
          else if (|mult_p[29:27]) target_curr_r <= 12'hFFF;
          else                    target_curr_r <= mult_p[26:15];
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
